// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction fetch stage for a multi-cycle processor. A single fetch PC
//   register drives a synchronous instruction memory. A three-state FSM
//   (ISSUE -> CAPTURE -> HOLD) presents the address and captures the returned
//   word. It then holds the word until the consumer accepts it.
//
// Ports
//   clk          rising-edge system clock
//   rst          asynchronous, active-high reset
//   im_addr      word address to instruction memory (pc[11:2])
//   im_dout      registered instruction word from memory
//   redirect     load redirect_pc as the next fetch PC, drop in-flight work
//   redirect_pc  branch/jump target (low two bits ignored)
//   ir_ready     consumer accepts the held instruction (only honoured in HOLD)
//   ir           held instruction word
//   ir_valid     ir / pc_out / pc_plus4 / range_err are valid
//   pc_out       address of the instruction in ir
//   pc_plus4     pc_out + 4, modulo 2^32
//   range_err    held instruction's address lies outside the 4 KiB window
//   retired      count of accepted instructions (wraps at 2^32)
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        range_err,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Fetch addresses are word aligned, so the low two bits are forced to zero.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic        capture_en;
  logic        accept;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ISSUE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A redirect restarts the fetch from any state.
  always_comb begin
    next_state = state;
    if (redirect) begin
      next_state = ISSUE;
    end else begin
      case (state)
        ISSUE:   next_state = CAPTURE;
        CAPTURE: next_state = HOLD;
        HOLD:    next_state = ir_ready ? ISSUE : HOLD;
        default: next_state = ISSUE;
      endcase
    end
  end

  // FSM outputs. A redirect suppresses both the capture and the handshake.
  // When redirect and ir_ready are both high in HOLD, the instruction is
  // discarded and is not counted.
  always_comb begin
    capture_en = 1'b0;
    accept     = 1'b0;
    if (!redirect) begin
      capture_en = (state == CAPTURE);
      accept     = (state == HOLD) && ir_ready;
    end
  end

  // The memory address comes straight from the live PC. The memory registers
  // it on the edge that ends ISSUE, so im_dout is valid throughout CAPTURE.
  assign im_addr  = pc[11:2];
  assign pc_plus4 = pc_out + 32'd4;

  // Datapath. The PC advances at capture time, so while an instruction is
  // held, im_addr already points at the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC_ALIGNED;
      ir        <= 32'd0;
      ir_valid  <= 1'b0;
      pc_out    <= 32'd0;
      range_err <= 1'b0;
      retired   <= 32'd0;
    end else begin
      if (redirect) begin
        pc       <= redirect_pc & 32'hFFFF_FFFC;
        ir_valid <= 1'b0;
      end else if (capture_en) begin
        ir        <= im_dout;
        pc_out    <= pc;
        range_err <= |pc[31:12];
        pc        <= pc + 32'd4;
        ir_valid  <= 1'b1;
      end else if (accept) begin
        ir_valid <= 1'b0;
        retired  <= retired + 32'd1;
      end
    end
  end

endmodule
